elevator_car_motion: RTL and testbench
======================================

# elevator_car_motion

Car-motion controller for the 4-floor elevator. It accepts one target-floor request at a time and steps the registered 2-bit car position one floor per travel interval toward the target. It then holds the door open for a fixed interval before accepting the next request. Its `floor` output is the 2-bit position code that drives the floor-change detector, so that detector receives exactly one change pulse per floor crossed.

## Interface
- `TRAVEL_CYCLES`, default 100, clock cycles to move one floor; legal range ≥ 2.
- `DOOR_CYCLES`, default 50, clock cycles the door stays open on arrival; legal range ≥ 1.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input 1: target-floor request present.
- `req_floor` input 2: requested floor, 0..3.
- `req_ready` output 1: request accepted this cycle if `req_valid` is also high.
- `floor` output 2: current car floor, registered.
- `moving` output 1: car travelling between floors.
- `dir_up` output 1: travelling upward; valid only while `moving`.
- `door_open` output 1: door open.
- `arrived` output 1: one-cycle pulse on reaching the target.

## Operation
- States are IDLE, MOVE, DOOR.
- **IDLE:**
  - `req_ready` is 1.
  - When `req_valid` is high, latch `req_floor` as `target`.
  - If `req_floor == floor`, go to DOOR and pulse `arrived`.
  - Otherwise go to MOVE, with `dir_up = (req_floor > floor)` and the travel counter cleared to 0.
- **MOVE:**
  - The counter runs 0..`TRAVEL_CYCLES`-1.
  - When the counter reaches the terminal value, `floor` changes by ±1 on that edge and the counter restarts at 0.
  - If the new floor equals `target`, go to DOOR on the same edge and pulse `arrived`.
  - `floor` never wraps: 0→3 and 3→0 transitions are impossible by construction, and the bench asserts this.
- **DOOR:**
  - `door_open` is 1; the counter runs 0..`DOOR_CYCLES`-1.
  - When the counter reaches the terminal value, go to IDLE.
- `req_ready` is 0 in MOVE and DOOR. Requests presented then are ignored, not queued, and the requester holds `req_valid`.
- `req_ready` is a combinational decode of state == IDLE. All other outputs are registered.
- **Reset values:**
  - state IDLE, `floor` 0, `target` 0, counter 0.
  - `moving` 0, `dir_up` 0, `door_open` 0, `arrived` 0.
  - `req_ready` is 1 from the first cycle after reset deasserts.
- **Reset mid-operation:** an asserted `rst` wins over every other event on that edge. The car returns to floor 0 and IDLE immediately, and any in-flight target is discarded.
- **Request with `req_floor == floor`:** the door opens with no change in `floor`, so no position change reaches downstream.

## Timing
- Let E be the edge on which a request is accepted and d = |target − floor| at acceptance.
- **d ≥ 1:**
  - `moving` = 1 from edge E.
  - `floor` steps at edges E + k·`TRAVEL_CYCLES` for k = 1..d.
  - At edge E + d·`TRAVEL_CYCLES`: `moving` goes to 0, `door_open` goes to 1, `arrived` is high for that one cycle.
  - IDLE, with `door_open` 0, at edge E + d·`TRAVEL_CYCLES` + `DOOR_CYCLES`.
- **d = 0:** `door_open` and `arrived` at edge E; IDLE at E + `DOOR_CYCLES`.
- `floor` is stable for ≥ `TRAVEL_CYCLES` cycles between steps, so at most one floor change occurs per travel interval.
- The earliest next acceptance is the edge after IDLE is re-entered, because `req_ready` follows the registered state.
- One shared counter is used, width $clog2(max(`TRAVEL_CYCLES`, `DOOR_CYCLES`)).

## Structure
- `elevator_pkg` holds:
  - `floor_t` (logic [1:0])
  - `NUM_FLOORS` = 4
  - the `car_state_t` enum {IDLE, MOVE, DOOR}
- The floor-change detector also imports `floor_t` from `elevator_pkg`.
- One sub-module, `cycle_timer`: a loadable up-counter with a terminal-count flag, reused for travel and door intervals. The FSM and position register stay in `elevator_car_motion`.

## Test plan
All scenarios use `TRAVEL_CYCLES` = 4 and `DOOR_CYCLES` = 3.
- **Reset:** `rst` high for 2 cycles, then low → `floor` 0, `moving` 0, `door_open` 0, `arrived` 0, `req_ready` 1.
- **0→3 up:** request floor 3 at edge E → `floor` reads 1 at E+4, 2 at E+8, 3 at E+12; `arrived` high for one cycle at E+12; `door_open` 1 for E+12..E+14; `req_ready` 1 from E+15.
- **3→1 down:** `dir_up` 0, `floor` reads 2 at E+4 and 1 at E+8; no other values ever appear on `floor`.
- **Same floor:** request floor 2 while at floor 2 → `door_open` 1 and `arrived` at E with no change in `floor`; IDLE at E+3.
- **Busy ignore:** hold `req_valid` with floor 0 during MOVE to 3 → ignored until IDLE, then accepted, and the car returns 3→0.
- **Reset mid-travel:** assert `rst` at E+6 during 0→3 → next cycle `floor` 0, `moving` 0, `req_ready` 1; no `arrived` pulse.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types for the elevator blocks.
//   floor_t      : 2-bit floor code (0..3), also used by the floor-change detector
//   NUM_FLOORS   : number of served floors
//   car_state_t  : car motion FSM states
package elevator_pkg;
    typedef logic [1:0] floor_t;
    localparam int NUM_FLOORS = 4;
    typedef enum logic [1:0] {IDLE, MOVE, DOOR} car_state_t;
endpackage

// File: rtl/elevator_car_motion_if.sv
// Request/status bundle between a requester (master) and the car (slave).
//   req_valid/req_floor : target-floor request, master -> car
//   req_ready           : car can take a request this cycle
//   floor               : registered car position
//   moving/dir_up       : travel status, dir_up meaningful only while moving
//   door_open/arrived   : door status and one-cycle arrival pulse
interface elevator_car_motion_if;
    import elevator_pkg::*;
    logic   req_valid;
    floor_t req_floor;
    logic   req_ready;
    floor_t floor;
    logic   moving;
    logic   dir_up;
    logic   door_open;
    logic   arrived;

    modport master (
        output req_valid, req_floor,
        input  req_ready, floor, moving, dir_up, door_open, arrived
    );
    modport slave (
        input  req_valid, req_floor,
        output req_ready, floor, moving, dir_up, door_open, arrived
    );
endinterface

// File: rtl/elevator_car_motion_cycle_timer.sv
// cycle_timer: up-counter with terminal-count flag, shared by travel and door
// intervals.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : force count to 0 (held while the owner is idle)
//   en_i     : count enable
//   term_i   : terminal value; count wraps to 0 on the edge after reaching it
//   tc_o     : count == term_i
module cycle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == term_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (en_i)  cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/elevator_car_motion.sv
// Car-motion controller for a 4-floor elevator. Accepts one target floor at a
// time, steps the registered floor one position per TRAVEL_CYCLES toward it,
// then holds the door open for DOOR_CYCLES before taking the next request.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/status interface (slave side)
// req_ready is a pure decode of the IDLE state; all other outputs registered.
module elevator_car_motion
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 100,
    parameter int DOOR_CYCLES   = 50
) (
    input logic                  clk,
    input logic                  rst,
    elevator_car_motion_if.slave bus
);
    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] TRAVEL_TC = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_TC   = CW'(DOOR_CYCLES - 1);

    car_state_t state_q, state_d;
    floor_t     floor_q, floor_d, target_q, target_d, next_floor;
    logic       moving_q, moving_d, dir_up_q, dir_up_d;
    logic       door_q, door_d, arrived_q, arrived_d;
    logic       tmr_tc;

    // Counter is parked at 0 in IDLE so both MOVE and DOOR start from a clean
    // count; in MOVE it wraps itself at each floor step, so DOOR entry from
    // MOVE also starts at 0.
    cycle_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == IDLE),
        .en_i   (state_q != IDLE),
        .term_i ((state_q == MOVE) ? TRAVEL_TC : DOOR_TC),
        .tc_o   (tmr_tc)
    );

    // dir_up always points at target, so this never wraps 0<->3.
    assign next_floor = dir_up_q ? floor_q + 2'd1 : floor_q - 2'd1;

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        target_d  = target_q;
        moving_d  = moving_q;
        dir_up_d  = dir_up_q;
        door_d    = door_q;
        arrived_d = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                target_d = bus.req_floor;
                if (bus.req_floor == floor_q) begin
                    state_d   = DOOR;
                    door_d    = 1'b1;
                    arrived_d = 1'b1;
                end else begin
                    state_d  = MOVE;
                    moving_d = 1'b1;
                    dir_up_d = (bus.req_floor > floor_q);
                end
            end
            MOVE: if (tmr_tc) begin
                floor_d = next_floor;
                if (next_floor == target_q) begin
                    state_d   = DOOR;
                    moving_d  = 1'b0;
                    door_d    = 1'b1;
                    arrived_d = 1'b1;
                end
            end
            DOOR: if (tmr_tc) begin
                state_d = IDLE;
                door_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            target_q  <= '0;
            moving_q  <= 1'b0;
            dir_up_q  <= 1'b0;
            door_q    <= 1'b0;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            target_q  <= target_d;
            moving_q  <= moving_d;
            dir_up_q  <= dir_up_d;
            door_q    <= door_d;
            arrived_q <= arrived_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.floor     = floor_q;
    assign bus.moving    = moving_q;
    assign bus.dir_up    = dir_up_q;
    assign bus.door_open = door_q;
    assign bus.arrived   = arrived_q;
endmodule

// File: tb/tb_elevator_car_motion.sv
// Bench for elevator_car_motion with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
// Expected outputs come from a timeline model: for a request from f to t with
// d=|t-f|, the outputs n cycles after acceptance follow directly from n, d,
// TRAVEL_CYCLES and DOOR_CYCLES.
module tb_elevator_car_motion;
    localparam int T = 4;
    localparam int D = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    elevator_car_motion_if bus();

    elevator_car_motion #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cur_floor = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // packed {floor[1:0], moving, dir_up, door_open, arrived, req_ready};
    // dir_up forced to 0 when not moving (only meaningful while moving)
    function automatic int model(input int f, input int t, input int n);
        int d, steps, fl, mv, up, dr, ar, rdy;
        d     = (t > f) ? t - f : f - t;
        steps = (n / T < d) ? n / T : d;
        fl    = (t > f) ? f + steps : f - steps;
        mv    = (n < d * T) ? 1 : 0;
        up    = (mv == 1 && t > f) ? 1 : 0;
        dr    = (n >= d * T && n < d * T + D) ? 1 : 0;
        ar    = (n == d * T) ? 1 : 0;
        rdy   = (n >= d * T + D) ? 1 : 0;
        return (fl << 5) | (mv << 4) | (up << 3) | (dr << 2) | (ar << 1) | rdy;
    endfunction

    function automatic int observe();
        int up;
        up = bus.moving ? int'(bus.dir_up) : 0;
        return (int'(bus.floor) << 5) | (int'(bus.moving) << 4) | (up << 3) |
               (int'(bus.door_open) << 2) | (int'(bus.arrived) << 1) | int'(bus.req_ready);
    endfunction

    // Floor-continuity monitor: outside reset, floor moves by exactly one.
    bit rst_seen = 1'b1;
    int prev_floor = 0;
    always @(posedge clk) rst_seen <= rst;
    always @(negedge clk) begin
        if (!rst_seen && int'(bus.floor) != prev_floor) begin
            int df;
            df = int'(bus.floor) - prev_floor;
            chk("floor_step_by_one", (df < 0) ? -df : df, 1);
        end
        prev_floor = int'(bus.floor);
    end

    // Called at a negedge with the car idle. mode 0: drop req_valid after
    // acceptance; 1: random noise requests while busy; 2: hold req_valid with
    // floor 0 throughout (left asserted on return).
    task automatic transact(input int t, input int mode, output int arr_n);
        int d, f, last;
        f = cur_floor;
        d = (t > f) ? t - f : f - t;
        last = d * T + D;
        arr_n = -1;
        if (!bus.req_ready) begin
            chk("ready_before_req", 0, 1);
            for (int i = 0; i < 100 && !bus.req_ready; i++) @(negedge clk);
        end
        bus.req_valid = 1'b1;
        bus.req_floor = 2'(t);
        for (int n = 0; n <= last; n++) begin
            @(negedge clk);
            chk($sformatf("timeline f%0d->t%0d n%0d", f, t, n), observe(), model(f, t, n));
            if (bus.arrived && arr_n < 0) arr_n = n;
            case (mode)
                1: begin
                    bus.req_valid = (n < last) ? 1'($urandom_range(1)) : 1'b0;
                    bus.req_floor = 2'($urandom_range(3));
                end
                2: begin
                    bus.req_valid = 1'b1;
                    bus.req_floor = 2'd0;
                end
                default: bus.req_valid = 1'b0;
            endcase
        end
        cur_floor = t;
    endtask

    typedef struct {
        int req;
        int exp_d;
        int exp_final;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int arr;
        vecs[0] = '{3, 3, 3};   // 0->3 up
        vecs[1] = '{1, 2, 1};   // 3->1 down
        vecs[2] = '{1, 0, 1};   // same floor
        vecs[3] = '{2, 1, 2};
        vecs[4] = '{2, 0, 2};   // same floor at 2
        vecs[5] = '{0, 2, 0};

        bus.req_valid = 1'b0;
        bus.req_floor = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_floor",   int'(bus.floor), 0);
        chk("reset_moving",  int'(bus.moving), 0);
        chk("reset_door",    int'(bus.door_open), 0);
        chk("reset_arrived", int'(bus.arrived), 0);
        chk("reset_ready",   int'(bus.req_ready), 1);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            transact(vecs[i].req, 0, arr);
            chk($sformatf("vec%0d_arrive_cycle", i), arr, vecs[i].exp_d * T);
            chk($sformatf("vec%0d_final_floor", i), int'(bus.floor), vecs[i].exp_final);
        end

        // Busy ignore: car to 3 with floor-0 request held; taken once idle.
        transact(3, 2, arr);
        chk("busy_first_arrive", arr, 3 * T);
        transact(0, 0, arr);
        chk("busy_return_floor", int'(bus.floor), 0);

        // Reset mid-travel: rst sampled at E+6 during 0->3.
        bus.req_valid = 1'b1;
        bus.req_floor = 2'd3;
        for (int n = 0; n <= 5; n++) begin
            @(negedge clk);
            chk($sformatf("midrst_timeline n%0d", n), observe(), model(0, 3, n));
            bus.req_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_floor",   int'(bus.floor), 0);
        chk("midrst_moving",  int'(bus.moving), 0);
        chk("midrst_ready",   int'(bus.req_ready), 1);
        chk("midrst_arrived", int'(bus.arrived), 0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("midrst_no_arrive", int'(bus.arrived), 0);
            chk("midrst_hold_floor", int'(bus.floor), 0);
        end
        cur_floor = 0;

        // Randomized requests with busy-time noise
        for (int i = 0; i < 25; i++) begin
            int t, f;
            f = cur_floor;
            t = int'($urandom_range(3));
            transact(t, 1, arr);
            chk("rand_arrive_cycle", arr, ((t > f) ? t - f : f - t) * T);
            chk("rand_final_floor", int'(bus.floor), t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
